regfile_sb: RTL and testbench

- Architectural register file with a per-register reservation scoreboard; sits between ID (read/reserve side) and WB (write side) of the 4-stage core (IF, ID, EX, WB).
- ID reads two source operands combinationally and reserves the destination register. WB writes the result and releases the reservation.
- ID uses the reserved flags to stall on RAW/WAW hazards.

---
 rtl/regfile_sb_pkg.sv | 27 ++
 rtl/regfile_sb_sb_bits.sv | 66 ++++++
 rtl/regfile_sb.sv | 88 ++++++++
 tb/tb_regfile_sb.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared sizing and lookup-port naming for the register file / scoreboard.
// The core, ID and WB stages import the same defaults so that register
// numbers and data words agree everywhere.
package regfile_sb_pkg;

  // Default geometry of the architectural register file.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREG   = 16;
  localparam int DEF_NUM_W  = 4;

  // Bit positions of the three busy lookups reported to ID.
  typedef enum logic [1:0] {
    LU_R0 = 2'd0,  // source operand 0
    LU_R1 = 2'd1,  // source operand 1
    LU_W  = 2'd2   // destination being reserved
  } lookup_e;

  localparam int NUM_LOOKUPS = 3;

  // True when a writeback strobe targets register num this cycle.
  function automatic logic wb_hits(input logic                 wb_en,
                                   input logic [DEF_NUM_W-1:0] wb_num,
                                   input logic [DEF_NUM_W-1:0] num);
    return wb_en && (wb_num == num);
  endfunction

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_sb_bits.sv
// Reservation-bit vector of the scoreboard: one bit per architectural
// register, set by ID when it issues a producer, cleared by WB when the
// result lands, and cleared wholesale on a pipeline flush. Also provides
// the "effective busy" lookups, which treat a register being written back
// this very cycle as already free (its value is bypassed to the reader).
module sb_bits
  import regfile_sb_pkg::*;
#(
  parameter int NREG  = DEF_NREG,
  parameter int NUM_W = DEF_NUM_W
) (
  input  logic             clk,
  input  logic             rst,
  // reserve side (ID)
  input  logic             set_en,
  input  logic [NUM_W-1:0] set_num,
  // release side (WB)
  input  logic             clr_en,
  input  logic [NUM_W-1:0] clr_num,
  // drop every reservation
  input  logic             flush,
  // busy lookups
  input  logic [NUM_W-1:0] r0_num,
  input  logic [NUM_W-1:0] r1_num,
  input  logic [NUM_W-1:0] w_num,
  output logic [NUM_LOOKUPS-1:0] busy,
  // raw reservation bit of the register WB is writing
  output logic             clr_rsv
);

  logic [NREG-1:0] rsv;
  logic [NREG-1:0] rsv_next;

  // Effective busy: reserved, unless WB is releasing that register right now.
  always_comb begin
    busy         = '0;
    busy[LU_R0]  = rsv[r0_num] && !(clr_en && (clr_num == r0_num));
    busy[LU_R1]  = rsv[r1_num] && !(clr_en && (clr_num == r1_num));
    busy[LU_W]   = rsv[w_num]  && !(clr_en && (clr_num == w_num));
    clr_rsv      = rsv[clr_num];
  end

  // Next reservation vector: flush clears all and swallows any new reserve;
  // otherwise release first, then reserve, so a same-register collision
  // leaves the new producer owning the register.
  always_comb begin
    // NOTE: every combinational output takes a full default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    rsv_next = rsv;
    if (flush) begin
      rsv_next = '0;
    end else begin
      if (clr_en) rsv_next[clr_num] = 1'b0;
      if (set_en) rsv_next[set_num] = 1'b1;
    end
  end

  // Reservation state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) rsv <= '0;
    else     rsv <= rsv_next;
  end

endmodule : sb_bits

// File: rtl/regfile_sb.sv
// Architectural register file with a per-register reservation scoreboard.
// ID reads two operands combinationally (with a bypass from the same-cycle
// WB write) and reserves its destination; WB writes the result and releases
// the reservation. A sticky err flags protocol violations: reserving a
// register that still has a producer in flight, or writing back a register
// nobody reserved. The write itself is performed even in the error cases.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG,
  parameter int NUM_W  = DEF_NUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_W-1:0]  r0_num,
  input  logic [NUM_W-1:0]  r1_num,
  output logic [DATA_W-1:0] r0_data,
  output logic [DATA_W-1:0] r1_data,
  input  logic              w_reserve,
  input  logic [NUM_W-1:0]  w_num,
  output logic [2:0]        reserved,
  input  logic              wb,
  input  logic [NUM_W-1:0]  wbr_num,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              err
);

  logic [DATA_W-1:0]      regs [NREG];
  logic [NUM_LOOKUPS-1:0] busy;
  logic                   wb_rsv;
  logic                   waw_err;
  logic                   unrsv_err;

  sb_bits #(
    .NREG  (NREG),
    .NUM_W (NUM_W)
  ) u_sb_bits (
    .clk     (clk),
    .rst     (rst),
    .set_en  (w_reserve),
    .set_num (w_num),
    .clr_en  (wb),
    .clr_num (wbr_num),
    .flush   (flush),
    .r0_num  (r0_num),
    .r1_num  (r1_num),
    .w_num   (w_num),
    .busy    (busy),
    .clr_rsv (wb_rsv)
  );

  assign reserved = busy;

  // Operand reads with WB bypass so a same-cycle writeback is seen at once.
  always_comb begin
    r0_data = regs[r0_num];
    r1_data = regs[r1_num];
    if (wb && (wbr_num == r0_num)) r0_data = wb_data;
    if (wb && (wbr_num == r1_num)) r1_data = wb_data;
  end

  // Protocol checks: WAW reserve of an in-flight register, or a writeback
  // to a register with no reservation (a flush legitimately orphans those).
  always_comb begin
    waw_err   = w_reserve && busy[LU_W];
    unrsv_err = wb && !wb_rsv && !flush;
  end

  // Register array: reset clears every entry, WB writes one per cycle.
  always_ff @(posedge clk) begin
    // NOTE: the array is reset on purpose -- architectural registers must
    // read 0 after reset, so this stays a flop array rather than a RAM.
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb) begin
      regs[wbr_num] <= wb_data;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                        err <= 1'b0;
    else if (waw_err || unrsv_err)  err <= 1'b1;
  end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios with literal
// expectations, then a randomized run compared against a behavioural model
// of the register file (plain arrays updated from the architectural rules).
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int NR = DEF_NREG;
  localparam int NW = DEF_NUM_W;

  logic          clk = 1'b0;
  logic          rst;
  logic [NW-1:0] r0_num, r1_num, w_num, wbr_num;
  logic [DW-1:0] r0_data, r1_data, wb_data;
  logic          w_reserve, wb, flush, err;
  logic [2:0]    reserved;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model state.
  logic [DW-1:0] m_regs [NR];
  bit            m_rsv  [NR];
  bit            m_err;

  regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .r0_num    (r0_num),
    .r1_num    (r1_num),
    .r0_data   (r0_data),
    .r1_data   (r1_data),
    .w_reserve (w_reserve),
    .w_num     (w_num),
    .reserved  (reserved),
    .wb        (wb),
    .wbr_num   (wbr_num),
    .wb_data   (wb_data),
    .flush     (flush),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] exp_data(input logic [NW-1:0] n);
    if (wb && wbr_num == n) return wb_data;
    return m_regs[n];
  endfunction

  function automatic logic exp_busy(input logic [NW-1:0] n);
    return m_rsv[n] && !(wb && wbr_num == n);
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit e;
    e = m_err;
    if (w_reserve && exp_busy(w_num))        e = 1'b1;
    if (wb && !m_rsv[wbr_num] && !flush)     e = 1'b1;
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = '0;
        m_rsv[i]  = 1'b0;
      end
      m_err = 1'b0;
    end else begin
      if (wb) m_regs[wbr_num] = wb_data;
      if (flush) begin
        for (int i = 0; i < NR; i++) m_rsv[i] = 1'b0;
      end else begin
        if (wb)        m_rsv[wbr_num] = 1'b0;
        if (w_reserve) m_rsv[w_num]   = 1'b1;
      end
      m_err = e;
    end
  endtask

  // One clock edge; inputs are changed only after it.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; w_reserve = 1'b0; wb = 1'b0; flush = 1'b0;
    r0_num = '0; r1_num = '0; w_num = '0; wbr_num = '0; wb_data = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; r0_num = 4'd3; r1_num = 4'd15;
    #1;
    tests_run++;
    if (r0_data !== 32'h0) begin
      tests_failed++; $display("FAIL reset_r0_data: got %h want %h", r0_data, 32'h0);
    end
    tests_run++;
    if (r1_data !== 32'h0) begin
      tests_failed++; $display("FAIL reset_r1_data: got %h want %h", r1_data, 32'h0);
    end
    tests_run++;
    if (reserved !== 3'b000) begin
      tests_failed++; $display("FAIL reset_reserved: got %b want %b", reserved, 3'b000);
    end
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_err: got %b want %b", err, 1'b0);
    end
  endtask

  task automatic test_write_read();
    idle();
    wb = 1'b1; wbr_num = 4'd5; wb_data = 32'hDEADBEEF;
    tick();
    wb = 1'b0;
    #1;
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++; $display("FAIL unreserved_write_err: got %b want %b", err, 1'b1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; w_reserve = 1'b1; w_num = 4'd5;
    tick();
    w_reserve = 1'b0; wb = 1'b1; wbr_num = 4'd5; wb_data = 32'hDEADBEEF;
    tick();
    wb = 1'b0; r0_num = 4'd5;
    #1;
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++; $display("FAIL reserved_write_err: got %b want %b", err, 1'b0);
    end
    tests_run++;
    if (r0_data !== 32'hDEADBEEF) begin
      tests_failed++; $display("FAIL write_read_data: got %h want %h", r0_data, 32'hDEADBEEF);
    end
    tests_run++;
    if (reserved[0] !== 1'b0) begin
      tests_failed++; $display("FAIL write_release: got %b want %b", reserved[0], 1'b0);
    end
  endtask

  task automatic test_bypass();
    idle();
    w_reserve = 1'b1; w_num = 4'd7;
    tick();
    w_reserve = 1'b0; r0_num = 4'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (reserved[0] !== 1'b1) begin
        tests_failed++; $display("FAIL bypass_busy_wait%0d: got %b want %b", i, reserved[0], 1'b1);
      end
      tick();
    end
    wb = 1'b1; wbr_num = 4'd7; wb_data = 32'h00000042;
    #1;
    tests_run++;
    if (r0_data !== 32'h00000042) begin
      tests_failed++; $display("FAIL bypass_data: got %h want %h", r0_data, 32'h42);
    end
    tests_run++;
    if (reserved[0] !== 1'b0) begin
      tests_failed++; $display("FAIL bypass_release: got %b want %b", reserved[0], 1'b0);
    end
    tick();
    wb = 1'b0;
    #1;
    tests_run++;
    if (r0_data !== 32'h00000042 || reserved[0] !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL bypass_after: got data=%h busy=%b err=%b want data=%h busy=0 err=0",
               r0_data, reserved[0], err, 32'h42);
    end
  endtask

  task automatic test_collision();
    idle();
    w_reserve = 1'b1; w_num = 4'd2;
    tick();
    wb = 1'b1; wbr_num = 4'd2; wb_data = 32'h00000011;
    w_reserve = 1'b1; w_num = 4'd2;
    #1;
    tests_run++;
    if (reserved[2] !== 1'b0) begin
      tests_failed++; $display("FAIL collision_w_busy: got %b want %b", reserved[2], 1'b0);
    end
    tick();
    idle();
    r0_num = 4'd2;
    #1;
    tests_run++;
    if (reserved[0] !== 1'b1) begin
      tests_failed++; $display("FAIL collision_rsv: got %b want %b", reserved[0], 1'b1);
    end
    tests_run++;
    if (r0_data !== 32'h00000011) begin
      tests_failed++; $display("FAIL collision_data: got %h want %h", r0_data, 32'h11);
    end
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++; $display("FAIL collision_err: got %b want %b", err, 1'b0);
    end
    // Release r2 so later scenarios start clean.
    wb = 1'b1; wbr_num = 4'd2; wb_data = 32'h00000011;
    tick();
    idle();
  endtask

  task automatic test_flush();
    logic [NW-1:0] nums [3];
    idle();
    nums[0] = 4'd1; nums[1] = 4'd4; nums[2] = 4'd9;
    for (int i = 0; i < 3; i++) begin
      w_reserve = 1'b1; w_num = nums[i];
      tick();
    end
    w_reserve = 1'b0;
    r0_num = 4'd1; r1_num = 4'd4; w_num = 4'd9;
    #1;
    tests_run++;
    if (reserved !== 3'b111) begin
      tests_failed++; $display("FAIL flush_before: got %b want %b", reserved, 3'b111);
    end
    flush = 1'b1; w_reserve = 1'b1; w_num = 4'd12;
    tick();
    flush = 1'b0; w_reserve = 1'b0; w_num = 4'd9;
    #1;
    tests_run++;
    if (reserved !== 3'b000) begin
      tests_failed++; $display("FAIL flush_cleared: got %b want %b", reserved, 3'b000);
    end
    w_num = 4'd12;
    #1;
    tests_run++;
    if (reserved[2] !== 1'b0) begin
      tests_failed++; $display("FAIL flush_reserve_ignored: got %b want %b", reserved[2], 1'b0);
    end
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++; $display("FAIL flush_err: got %b want %b", err, 1'b0);
    end
  endtask

  task automatic test_mid_reset();
    idle();
    w_reserve = 1'b1; w_num = 4'd3;
    tick();
    w_reserve = 1'b1; w_num = 4'd6;
    wb = 1'b1; wbr_num = 4'd3; wb_data = 32'hA5A5A5A5;
    tick();
    idle();
    r0_num = 4'd3; r1_num = 4'd6; w_num = 4'd6;
    #1;
    tests_run++;
    if (r0_data !== 32'hA5A5A5A5 || reserved !== 3'b110) begin
      tests_failed++;
      $display("FAIL midreset_before: got data=%h rsv=%b want data=%h rsv=%b",
               r0_data, reserved, 32'hA5A5A5A5, 3'b110);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (r0_data !== 32'h0) begin
      tests_failed++; $display("FAIL midreset_data: got %h want %h", r0_data, 32'h0);
    end
    tests_run++;
    if (reserved !== 3'b000) begin
      tests_failed++; $display("FAIL midreset_rsv: got %b want %b", reserved, 3'b000);
    end
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++; $display("FAIL midreset_err: got %b want %b", err, 1'b0);
    end
  endtask

  task automatic test_random();
    int start;
    bit found;
    idle();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst       = ($urandom_range(0, 47) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      w_reserve = $urandom_range(0, 1);
      wb        = $urandom_range(0, 1);
      r0_num    = NW'($urandom);
      r1_num    = NW'($urandom);
      w_num     = NW'($urandom);
      wb_data   = $urandom;
      wbr_num   = NW'($urandom);
      // Mostly write back registers that really are reserved.
      if ($urandom_range(0, 3) != 0) begin
        start = $urandom_range(0, NR - 1);
        found = 1'b0;
        for (int k = 0; k < NR; k++) begin
          if (!found && m_rsv[(start + k) % NR]) begin
            wbr_num = NW'((start + k) % NR);
            found   = 1'b1;
          end
        end
      end
      // Sometimes read the register being written to exercise the bypass.
      if ($urandom_range(0, 3) == 0) r0_num = wbr_num;
      #1;
      tests_run++;
      if (r0_data !== exp_data(r0_num) || r1_data !== exp_data(r1_num) ||
          reserved !== {exp_busy(w_num), exp_busy(r1_num), exp_busy(r0_num)} ||
          err !== m_err) begin
        tests_failed++;
        $display("FAIL random_cyc%0d: got r0=%h r1=%h rsv=%b err=%b want r0=%h r1=%h rsv=%b err=%b",
                 cyc, r0_data, r1_data, reserved, err,
                 exp_data(r0_num), exp_data(r1_num),
                 {exp_busy(w_num), exp_busy(r1_num), exp_busy(r0_num)}, m_err);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_rsv[i]  = 1'b0;
    end
    m_err = 1'b0;
    test_reset();
    test_write_read();
    test_bypass();
    test_collision();
    test_flush();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_regfile_sb
